// File: rtl/serial_adder_8bit_if.sv
// serial_adder_8bit_if: operand/result bundle for the bit-serial adder.
// master drives the request, slave returns the result.
interface serial_adder_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CarryIn;
  logic [WIDTH-1:0] Sum;
  logic             error;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, CarryIn,
    input  Sum, error, busy, done
  );

  modport slave (
    input  start, A, B, CarryIn,
    output Sum, error, busy, done
  );
endinterface

// File: rtl/serial_adder_8bit.sv
// serial_adder_8bit: one full-adder slice plus carry FF, LSB first.
// Sum fills from the MSB; error is the carry out of the top bit.
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_8bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  st_t              st;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;

  logic s;
  logic cn;
  logic ld;
  logic last;

  // Full-adder slice on the current LSBs and the accept condition.
  always_comb begin
    s    = a_q[0] ^ b_q[0] ^ c_q;
    cn   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    ld   = bus.start & ((st == IDLE) | (st == DONE));
    last = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM with datapath; busy/done are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (ld) begin
      st     <= RUN;
      a_q    <= bus.A;
      b_q    <= bus.B;
      c_q    <= bus.CarryIn;
      cnt    <= '0;
      sum_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        RUN: begin
          sum_q <= {s, sum_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= cn;
          cnt   <= cnt + CW'(1);
          if (last) begin
            err_q  <= cn;
            st     <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          st     <= IDLE;
          done_q <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.Sum   = sum_q;
  assign bus.error = err_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
